// File: rtl/new_task_recv_pkg.sv
// Constants shared with the rest of the OmpSs manager: header field offsets and ack codes.
// Each header count field is 8 bits wide.
package new_task_recv_pkg;

  localparam int unsigned NUM_ARGS_OFFSET = 32;
  localparam int unsigned NUM_DEPS_OFFSET = 40;
  localparam int unsigned NUM_COPS_OFFSET = 48;

  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_FINAL_CODE  = 8'h02;

  function automatic logic [7:0] hdr_field(input logic [63:0] hdr, input int unsigned offset);
    return hdr[offset +: 8];
  endfunction

endpackage

// File: rtl/new_task_recv_if.sv
// Valid/ready word stream with source id and last flag; used for the spawn, ack and out buses.
interface new_task_recv_if #(
  parameter int unsigned ID_W = 4
) ();

  logic            valid;
  logic            ready;
  logic [63:0]     data;
  logic [ID_W-1:0] id;
  logic            last;

  modport master (output valid, output data, output id, output last, input ready);
  modport slave  (input valid, input data, input id, input last, output ready);

endinterface

// File: rtl/new_task_queue_mem.sv
// Simple dual-port RAM backing the task queue: one write port, one registered read port.
module new_task_queue_mem #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 69
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(Depth)-1:0] wr_addr,
  input  logic [Width-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(Depth)-1:0] rd_addr,
  output logic [Width-1:0]         rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/new_task_recv.sv
// Receives new-task packets, stores whole packets into a circular queue and acks the sender.
// Only fully received, accepted packets become visible on the out stream.
module new_task_recv
  import new_task_recv_pkg::*;
#(
  parameter int unsigned QUEUE_WORDS = 64,
  parameter int unsigned ID_W        = 4
) (
  input  logic            clk,
  input  logic            rst,
  new_task_recv_if.slave  spawn,
  input  logic            deps_enable,
  new_task_recv_if.master ack,
  new_task_recv_if.master out,
  output logic            len_err
);

  localparam int unsigned AW     = $clog2(QUEUE_WORDS);
  localparam int unsigned NEED_W = 11;
  localparam int unsigned CMP_W  = (NEED_W > AW + 2) ? NEED_W : AW + 2;
  localparam int unsigned MEM_W  = 64 + ID_W + 1;

  typedef enum logic [1:0] {StHdr, StRecv, StDrain, StAck} state_e;
  typedef logic [AW:0] ptr_t;

  state_e            state_q, state_d;
  ptr_t              wr_tmp_q, wr_tmp_d;
  ptr_t              commit_q, commit_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  logic [NEED_W-1:0] need_q, need_d;
  logic [NEED_W-1:0] count_q, count_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        code_q, code_d;
  logic              len_err_q, len_err_d;
  logic              out_valid_q, out_valid_d;

  logic              wr_en;
  logic              rd_en;
  logic [MEM_W-1:0]  rd_data;
  logic [NEED_W-1:0] hdr_need;
  logic [NEED_W-1:0] beat;
  logic              deps_blocked;
  logic              too_big;
  logic [AW:0]       used;
  logic [AW+1:0]     free;

  // Header word: need = 3 + nDeps + 2*nCops + nArgs, all fields zero-extended.
  assign hdr_need = NEED_W'(3)
                  + NEED_W'(hdr_field(spawn.data, NUM_DEPS_OFFSET))
                  + (NEED_W'(hdr_field(spawn.data, NUM_COPS_OFFSET)) << 1)
                  + NEED_W'(hdr_field(spawn.data, NUM_ARGS_OFFSET));

  assign deps_blocked = (hdr_field(spawn.data, NUM_DEPS_OFFSET) != 8'd0) && !deps_enable;

  // Pointers carry one extra bit, so the difference is the occupancy even across a wrap.
  assign used    = wr_tmp_q - rd_ptr_q;
  assign free    = (AW + 2)'(QUEUE_WORDS) - {1'b0, used};
  assign too_big = CMP_W'(hdr_need) > CMP_W'(free);
  assign beat    = count_q + NEED_W'(1);

  always_comb begin
    state_d     = state_q;
    wr_tmp_d    = wr_tmp_q;
    commit_d    = commit_q;
    need_d      = need_q;
    count_d     = count_q;
    id_d        = id_q;
    code_d      = code_q;
    len_err_d   = len_err_q;
    wr_en       = 1'b0;
    spawn.ready = 1'b0;
    ack.valid   = 1'b0;

    unique case (state_q)
      StHdr: begin
        spawn.ready = 1'b1;
        if (spawn.valid) begin
          id_d    = spawn.id;
          need_d  = hdr_need;
          count_d = NEED_W'(1);
          if (deps_blocked) begin
            code_d  = ACK_FINAL_CODE;
            state_d = spawn.last ? StAck : StDrain;
          end else if (too_big) begin
            code_d  = ACK_REJECT_CODE;
            state_d = spawn.last ? StAck : StDrain;
          end else if (spawn.last) begin
            // need is at least 3, so a lone header is always short
            code_d    = ACK_REJECT_CODE;
            len_err_d = 1'b1;
            state_d   = StAck;
          end else begin
            wr_en    = 1'b1;
            wr_tmp_d = wr_tmp_q + ptr_t'(1);
            state_d  = StRecv;
          end
        end
      end

      StRecv: begin
        spawn.ready = 1'b1;
        if (spawn.valid) begin
          count_d = beat;
          if (beat > need_q) begin
            // Beat beyond the header's length is not stored: the space was never reserved.
            wr_tmp_d  = commit_q;
            len_err_d = 1'b1;
            code_d    = ACK_REJECT_CODE;
            state_d   = spawn.last ? StAck : StDrain;
          end else begin
            wr_en    = 1'b1;
            wr_tmp_d = wr_tmp_q + ptr_t'(1);
            if (spawn.last) begin
              state_d = StAck;
              if (beat < need_q) begin
                wr_tmp_d  = commit_q;
                len_err_d = 1'b1;
                code_d    = ACK_REJECT_CODE;
              end else begin
                commit_d = wr_tmp_q + ptr_t'(1);
                code_d   = ACK_OK_CODE;
              end
            end
          end
        end
      end

      StDrain: begin
        spawn.ready = 1'b1;
        if (spawn.valid && spawn.last) begin
          state_d = StAck;
        end
      end

      StAck: begin
        ack.valid = 1'b1;
        if (ack.ready) begin
          state_d = StHdr;
        end
      end

      default: state_d = StHdr;
    endcase

    if (rst) begin
      spawn.ready = 1'b0;
    end
  end

  assign ack.data = {56'd0, code_q};
  assign ack.id   = id_q;
  assign ack.last = 1'b1;
  assign len_err  = len_err_q;

  // Output register refills whenever it is empty or being consumed.
  always_comb begin
    rd_en       = (rd_ptr_q != commit_q) && (!out_valid_q || out.ready);
    rd_ptr_d    = rd_en ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    out_valid_d = rd_en ? 1'b1 : (out_valid_q && !out.ready);
  end

  assign out.valid = out_valid_q;
  assign {out.last, out.id, out.data} = rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHdr;
      wr_tmp_q    <= '0;
      commit_q    <= '0;
      rd_ptr_q    <= '0;
      need_q      <= '0;
      count_q     <= '0;
      id_q        <= '0;
      code_q      <= '0;
      len_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_tmp_q    <= wr_tmp_d;
      commit_q    <= commit_d;
      rd_ptr_q    <= rd_ptr_d;
      need_q      <= need_d;
      count_q     <= count_d;
      id_q        <= id_d;
      code_q      <= code_d;
      len_err_q   <= len_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  new_task_queue_mem #(
    .Depth (QUEUE_WORDS),
    .Width (MEM_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en && !rst),
    .wr_addr (wr_tmp_q[AW-1:0]),
    .wr_data ({spawn.last, spawn.id, spawn.data}),
    .rd_en   (rd_en && !rst),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: doc/new_task_recv.md
# new_task_recv

Receives new-task packets from task-creating accelerators, checks that the whole packet fits in an internal circular queue, stores it, and returns a one-beat acknowledge (OK / REJECT / FINAL) to the originating accelerator. It sits directly downstream of the accelerator spawn port in the OmpSs manager and feeds committed task packets, unchanged, to the scheduler stage. Partially received or rejected packets are never visible downstream.

## Interface
Parameters:
- QUEUE_WORDS, 64: queue depth in 64-bit words; power of two, ≥ 16.
- ID_W, 4: width of the accelerator id field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- spawn_valid / spawn_ready  in / out  1  inbound packet handshake.
- spawn_data  in  64  packet word.
- spawn_id  in  ID_W  source accelerator.
- spawn_last  in  1  last packet word.
- deps_enable  in  1  dependence tracking available; sampled on the header beat.
- ack_valid / ack_ready  out / in  1  acknowledge handshake.
- ack_data  out  64  [7:0] ack code, all other bits 0.
- ack_dest  out  ID_W  id captured from the header beat.
- ack_last  out  1  constant 1.
- out_valid / out_ready  out / in  1  committed-packet handshake toward the scheduler.
- out_data  out  64  stored word.
- out_id  out  ID_W  stored source id.
- out_last  out  1  stored last flag.
- len_err  out  1  sticky; packet length did not match its header.

## Operation
- Packet layout: header, ptid, ttype, then nDeps deps, then nCops × 2 copy words, then nArgs args.
- Required words: need = 3 + nDeps + 2·nCops + nArgs. Compute it in 11 bits, unsigned.
- FSM states:
  - HDR: spawn_ready=1. On the header beat, latch spawn_id and need, and set beat count to 1.
    - nDeps>0 and deps_enable=0: go to DRAIN, code = ACK_FINAL_CODE.
    - Otherwise, need > free: go to DRAIN, code = ACK_REJECT_CODE.
    - Otherwise: write the header at wr_tmp, go to RECV.
  - RECV: spawn_ready=1. Write each beat at wr_tmp+1 and count it.
    - Early last (count+1 < need): roll wr_tmp back to commit, set len_err, code REJECT, go to ACK.
    - Over-length beat (count+1 > need) when last is not set: roll back, set len_err, go to DRAIN with REJECT.
    - Correct last: commit ← wr_tmp+1, code OK, go to ACK.
  - DRAIN: spawn_ready=1. Discard beats until last, then go to ACK.
  - ACK: ack_valid=1. On ack_ready, go to HDR.
- free = QUEUE_WORDS − (wr_tmp − rd_ptr). Pointers are one bit wider than the address, so wrap is implicit.
- Read side only sees [rd_ptr, commit). out_valid when a registered word is present. Its last flag comes from the stored spawn_last.
- Simultaneous commit and read are both honoured.
- A one-beat packet (header with last) has need=3, so it takes the early-last path: REJECT plus len_err.

## Timing
- Reset values: spawn_ready=0 on the reset cycle and HDR afterwards. ack_valid=0, out_valid=0, len_err=0. All pointers 0, state HDR.
- A packet in progress during reset is discarded, and no ack is sent for it.
- The ack is presented the cycle after the last beat. It is held stable until ack_ready.
- Commit to out_valid latency: 2 cycles (one cycle for the pointer update, one registered memory read).
- With out_ready held at 1 the output sustains 1 word/cycle. When out_ready is low, out_data, out_id and out_last are held.
- Input throughput is 1 beat/cycle. Between packets there is a minimum of one ACK cycle, during which spawn_ready=0.

## Structure
- Shared OmpSsManager package holds: NUM_ARGS_OFFSET, NUM_DEPS_OFFSET, NUM_COPS_OFFSET, and ACK_OK_CODE / ACK_REJECT_CODE / ACK_FINAL_CODE.
- Local to the block: the FSM enum and the need width.
- One sub-module, new_task_queue_mem: simple dual-port RAM, QUEUE_WORDS × (64+ID_W+1), registered read.

## Test plan
- Packet with nArgs=2, nDeps=1, nCops=1 (need=8), empty queue, id=3 -> ack OK, dest=3; the same 8 words appear on out with last on word 8.
- Pre-fill to 60/64 words, send need=8 -> REJECT. The packet is drained, nothing appears on out, and free is unchanged.
- nDeps=2 with deps_enable=0 -> FINAL. Resend with nDeps=0 -> OK.
- Header says need=6 but last arrives on beat 4 -> REJECT, len_err=1, commit unchanged, no out traffic.
- Fill across the wrap boundary (rd_ptr=60, eight-word packet) with out_ready toggling every cycle -> words are correct and in order, last on the correct beat.
- rst asserted on beat 3 of an 8-word packet -> no ack, out_valid stays 0, and the next packet is acked OK.
